// File: rtl/key_debounce_repeat_pkg.sv
// Shared definitions for the key debounce / auto-repeat block.
// Holds the per-channel state encoding, the board key index map and
// the width helpers used by the tick divider and the ms counters.
package key_debounce_repeat_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HOLD_DELAY = 3'd2,
        HOLD_RPT   = 3'd3,
        REL_DB     = 3'd4
    } chanState_t;

    // Bit positions of the setting keys on key_raw / key_pulse / key_level.
    localparam int KEY_HOUR_UP = 0;
    localparam int KEY_HOUR_DN = 1;
    localparam int KEY_MIN_UP  = 2;
    localparam int KEY_MIN_DN  = 3;

    // Number of bits needed to hold the values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce_repeat_if.sv
// Key bus between the board buttons, the conditioning stage and the setting logic.
// master: drives key_raw, consumes key_pulse / key_level / tick_1ms.
// slave:  the conditioning stage itself.
interface key_debounce_repeat_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_pulse;
    logic [N_KEYS-1:0] key_level;
    logic              tick_1ms;

    modport master (
        output key_raw,
        input  key_pulse,
        input  key_level,
        input  tick_1ms
    );

    modport slave (
        input  key_raw,
        output key_pulse,
        output key_level,
        output tick_1ms
    );
endinterface

// File: rtl/key_debounce_repeat_channel.sv
// One key: 2-FF synchroniser, debounce / typematic FSM and ms counter.
// Latency: 2 cycles + DEBOUNCE_MS ticks from a clean press to keyPulse.
// No backpressure: keyPulse is a fire-and-forget one-cycle strobe.
// Ports: CLK_50/CR clock and async reset; advance = high on the edge that
// opens a tick cycle; keyRaw raw pin; keyPulse press/repeat strobe; keyLevel
// debounced pressed state.
module key_debounce_repeat_channel
    import key_debounce_repeat_pkg::*;
#(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 600,
    parameter int REPEAT_RATE_MS  = 150,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic CLK_50,
    input  logic CR,
    input  logic advance,
    input  logic keyRaw,
    output logic keyPulse,
    output logic keyLevel
);
    localparam int   MS_W     = clog2(maxOf3(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS) + 1);
    localparam logic RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             syncA;
    logic             syncB;
    logic             pressed;
    chanState_t       state;
    logic [MS_W-1:0]  msCnt;
    logic [MS_W-1:0]  msNext;

    // XOR with the released level normalises polarity to pressed = 1.
    assign pressed = syncB ^ RELEASED;
    assign msNext  = msCnt + MS_W'(1);

    // The FSM steps on the edge that opens the tick cycle, so the registered
    // pulse and level changes coincide with tick_1ms rather than trailing it.
    // Terminal compares use >= so the counter can never run past its limit.
    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            syncA    <= RELEASED;
            syncB    <= RELEASED;
            state    <= IDLE;
            msCnt    <= '0;
            keyPulse <= 1'b0;
            keyLevel <= 1'b0;
        end else begin
            syncA    <= keyRaw;
            syncB    <= syncA;
            keyPulse <= 1'b0;
            if (advance) begin
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            msCnt <= MS_W'(1);
                            state <= PRESS_DB;
                        end
                    end
                    PRESS_DB: begin
                        if (!pressed) begin
                            msCnt <= '0;
                            state <= IDLE;
                        end else if (msNext >= MS_W'(DEBOUNCE_MS)) begin
                            keyLevel <= 1'b1;
                            keyPulse <= 1'b1;
                            msCnt    <= '0;
                            state    <= HOLD_DELAY;
                        end else begin
                            msCnt <= msNext;
                        end
                    end
                    HOLD_DELAY: begin
                        if (!pressed) begin
                            msCnt <= MS_W'(1);
                            state <= REL_DB;
                        end else if (msNext >= MS_W'(REPEAT_DELAY_MS)) begin
                            keyPulse <= 1'b1;
                            msCnt    <= '0;
                            state    <= HOLD_RPT;
                        end else begin
                            msCnt <= msNext;
                        end
                    end
                    HOLD_RPT: begin
                        if (!pressed) begin
                            msCnt <= MS_W'(1);
                            state <= REL_DB;
                        end else if (msNext >= MS_W'(REPEAT_RATE_MS)) begin
                            keyPulse <= 1'b1;
                            msCnt    <= '0;
                        end else begin
                            msCnt <= msNext;
                        end
                    end
                    REL_DB: begin
                        // A bounce back to pressed resumes repeating without a new pulse.
                        if (pressed) begin
                            msCnt <= '0;
                            state <= HOLD_RPT;
                        end else if (msNext >= MS_W'(DEBOUNCE_MS)) begin
                            keyLevel <= 1'b0;
                            msCnt    <= '0;
                            state    <= IDLE;
                        end else begin
                            msCnt <= msNext;
                        end
                    end
                    default: begin
                        msCnt <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/key_debounce_repeat.sv
// Setting-key conditioning: shared 1 ms tick plus one debounce/repeat channel per key.
// Latency: 2 cycles + DEBOUNCE_MS ticks press-to-pulse; tick_1ms is a registered strobe.
// No backpressure: pulses are single-cycle strobes the consumer must sample.
// Ports: CLK_50 clock, CR async active-high reset, keyBus (slave) carries
// key_raw in and key_pulse / key_level / tick_1ms out.
module key_debounce_repeat
    import key_debounce_repeat_pkg::*;
#(
    parameter int CLK_Freq        = 50000000,
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 600,
    parameter int REPEAT_RATE_MS  = 150,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                  CLK_50,
    input  logic                  CR,
    key_debounce_repeat_if.slave  keyBus
);
    localparam int TICK_DIV = CLK_Freq / 1000;
    localparam int TICK_W   = clog2(TICK_DIV);

    logic [TICK_W-1:0] tickCnt;
    logic              tickNext;
    logic              tickQ;
    logic [N_KEYS-1:0] pulseVec;
    logic [N_KEYS-1:0] levelVec;

    // Look one count ahead so the registered strobe is high exactly while
    // tickCnt == TICK_DIV-1; channels use the same look-ahead to step.
    assign tickNext = (tickCnt == TICK_W'(TICK_DIV - 2));

    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            tickCnt <= '0;
            tickQ   <= 1'b0;
        end else begin
            tickQ   <= tickNext;
            tickCnt <= (tickCnt == TICK_W'(TICK_DIV - 1)) ? '0 : tickCnt + TICK_W'(1);
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : gChan
        key_debounce_repeat_channel #(
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) uChan (
            .CLK_50   (CLK_50),
            .CR       (CR),
            .advance  (tickNext),
            .keyRaw   (keyBus.key_raw[g]),
            .keyPulse (pulseVec[g]),
            .keyLevel (levelVec[g])
        );
    end

    assign keyBus.key_pulse = pulseVec;
    assign keyBus.key_level = levelVec;
    assign keyBus.tick_1ms  = tickQ;
endmodule
